// File: rtl/disto_4x4_acc.sv
// ---------------------------------------------------------------------------
// disto_4x4_acc
//
// Macroblock distortion accumulator. Each accepted sub-block contributes
// |sum_a - sum_b| >> SHIFT. Contributions are summed over BLOCK_NUM
// sub-blocks, and the total is presented on disto together with a one-cycle
// done pulse.
//
// Optional feature macro: DISTO_TLAMBDA_EN
//   When defined, the tlambda port is present and an extra register stage
//   scales the accumulated value: disto = min((tlambda*acc + 128) >> 8, 2^32-1).
//   This adds one cycle of latency.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   start      in   1   pulse: open a new macroblock (aborts any open one)
//   sum_valid  in   1   pulse: sum_a/sum_b valid (accepted only in ACC)
//   sum_a      in  32   signed weighted sum, source block
//   sum_b      in  32   signed weighted sum, reconstructed block
//   tlambda    in  16   unsigned scale factor (DISTO_TLAMBDA_EN only)
//   busy       out  1   high from the cycle after start until done
//   disto      out 32   macroblock distortion, held until the next done
//   done       out  1   pulse: disto valid
// ---------------------------------------------------------------------------
module disto_4x4_acc #(
   parameter int BLOCK_NUM = 16,
   parameter int SHIFT     = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sum_valid,
   input  logic signed [31:0] sum_a,
   input  logic signed [31:0] sum_b,
`ifdef DISTO_TLAMBDA_EN
   input  logic [15:0]        tlambda,
`endif
   output logic               busy,
   output logic [31:0]        disto,
   output logic               done
);

   localparam int DATA_W = 32;
   localparam logic [4:0] LAST_CNT = 5'(BLOCK_NUM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t              state;
   logic [4:0]          cnt;
   logic                accept;
   logic                vld_p1;
   logic [DATA_W-1:0]   d_p1;
   logic [DATA_W-1:0]   acc_p2;

   // |a - b| >> SHIFT, with the difference formed at 33 bits so that the
   // extreme pair (+max, -min) cannot wrap. The magnitude always fits 32 bits.
   function automatic logic [DATA_W-1:0] abs_shift(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [DATA_W:0] diff;
      logic [DATA_W-1:0]      mag;
      diff = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
      if (diff[DATA_W])
         mag = DATA_W'(-diff);
      else
         mag = DATA_W'(diff);
      return mag >> SHIFT;
   endfunction

`ifdef DISTO_TLAMBDA_EN
   logic [47:0] prod_p3;

   // Round to nearest on the 8-bit fixed-point scale, then clamp to 32 bits.
   function automatic logic [DATA_W-1:0] round_sat(input logic [47:0] p);
      logic [48:0] r;
      logic [48:0] q;
      r = {1'b0, p} + 49'd128;
      q = r >> 8;
      if (|q[48:DATA_W])
         return '1;
      else
         return q[DATA_W-1:0];
   endfunction
`endif

   // A start in the same cycle always wins, so its coincident valid is dropped.
   assign accept = sum_valid && (state == ACC) && !start;

   // ---- stage 1: absolute difference and shift ----
   always_ff @(posedge clk) begin
      d_p1 <= abs_shift(sum_a, sum_b);
   end

`ifdef DISTO_TLAMBDA_EN
   // ---- stage 3: tlambda scaling ----
   always_ff @(posedge clk) begin
      if (state == DRAIN && !vld_p1)
         prod_p3 <= 48'(tlambda) * 48'(acc_p2);
   end
`endif

   // ---- stage 2: accumulate, plus control FSM and output registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc_p2 <= '0;
         vld_p1 <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         disto  <= '0;
      end else begin
         done   <= 1'b0;
         vld_p1 <= accept;
         if (vld_p1)
            acc_p2 <= acc_p2 + d_p1;

         if (start) begin
            // Abort anything in flight; no done is produced for it.
            state  <= ACC;
            cnt    <= '0;
            acc_p2 <= '0;
            vld_p1 <= 1'b0;
            busy   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
               end
               ACC: begin
                  if (accept) begin
                     cnt <= cnt + 5'd1;
                     if (cnt == LAST_CNT)
                        state <= DRAIN;
                  end
               end
               DRAIN: begin
                  // Once stage 1 is empty the accumulator holds the final sum.
                  if (!vld_p1) begin
                     state <= OUT;
`ifndef DISTO_TLAMBDA_EN
                     disto <= acc_p2;
                     done  <= 1'b1;
                     busy  <= 1'b0;
`endif
                  end
               end
               OUT: begin
`ifdef DISTO_TLAMBDA_EN
                  disto <= round_sat(prod_p3);
                  done  <= 1'b1;
                  busy  <= 1'b0;
`endif
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
